// File: rtl/sha256_host_driver_if.sv
// rtl/sha256_host_driver_if.sv - load/fetch/ack bus between the host driver and the SHA-256 interface block
interface sha256_host_driver_if;
  logic        load;
  logic        fetch;
  logic [15:0] idata;
  logic        ack;
  logic [15:0] odata;
  logic        busy_valid;

  modport master (output load, fetch, idata, input ack, odata, busy_valid);
  modport slave  (input load, fetch, idata, output ack, odata, busy_valid);
endinterface

// File: rtl/sha256_host_driver.sv
// rtl/sha256_host_driver.sv - streams one 512-bit block to the SHA-256 core as 16-bit words and reads back the digest
module sha256_host_driver #(
  parameter int GAP_CYC = 2,
  parameter int ACK_TO  = 15,
  parameter int CORE_TO = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [511:0]         blk_in,
  output logic                 ready,
  output logic                 done,
  output logic [255:0]         digest,
  output logic                 err,
  sha256_host_driver_if.master bus
);
  localparam int TO_M1  = (ACK_TO > CORE_TO) ? ACK_TO : CORE_TO;
  localparam int TO_MAX = (TO_M1 > GAP_CYC) ? TO_M1 : GAP_CYC;
  localparam int TW     = $clog2(TO_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, LD_REQ, LD_ACK, LD_GAP, CORE_HI, CORE_LO, FT_REQ, FT_ACK, FT_GAP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [511:0]  blk_q, blk_d;
  logic [4:0]    word_cnt_q, word_cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          load_q, load_d;
  logic          fetch_q, fetch_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   idata_q, idata_d;
  logic [255:0]  digest_q, digest_d;

  logic ack_to_hit, core_to_hit, gap_hit;

  // One shared counter times acks, core edges and gaps; it restarts on every state change.
  assign ack_to_hit  = (to_q == TW'(ACK_TO - 1));
  assign core_to_hit = (to_q == TW'(CORE_TO - 1));
  assign gap_hit     = (to_q == TW'(GAP_CYC - 1));

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    idata_d    = idata_q;
    digest_d   = digest_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d      = blk_in;
          err_d      = 1'b0;
          word_cnt_d = 5'd0;
          state_d    = LD_REQ;
        end
      end
      LD_REQ: state_d = LD_ACK;
      LD_ACK: begin
        if (bus.ack) begin
          word_cnt_d = word_cnt_q + 5'd1;
          state_d    = (word_cnt_q == 5'd31) ? CORE_HI : LD_GAP;
        end else if (ack_to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      LD_GAP: if (gap_hit) state_d = LD_REQ;
      CORE_HI: begin
        if (bus.busy_valid) begin
          state_d = CORE_LO;
        end else if (core_to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      CORE_LO: begin
        if (!bus.busy_valid) begin
          word_cnt_d = 5'd0;
          state_d    = FT_REQ;
        end else if (core_to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      FT_REQ: state_d = FT_ACK;
      FT_ACK: begin
        if (bus.ack) begin
          // Slot j occupies bits 255-16j down to 240-16j.
          digest_d[{~word_cnt_q[3:0], 4'hF} -: 16] = bus.odata;
          word_cnt_d = word_cnt_q + 5'd1;
          state_d    = (word_cnt_q[3:0] == 4'd15) ? DONE : FT_GAP;
        end else if (ack_to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      FT_GAP: if (gap_hit) state_d = FT_REQ;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == LD_REQ) idata_d = blk_d[{~word_cnt_d, 4'hF} -: 16];
    to_d    = (state_d != state_q) ? '0 : to_q + 1'b1;
    load_d  = (state_d == LD_REQ);
    fetch_d = (state_d == FT_REQ);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      word_cnt_q <= '0;
      to_q       <= '0;
      load_q     <= 1'b0;
      fetch_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      idata_q    <= '0;
      digest_q   <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      word_cnt_q <= word_cnt_d;
      to_q       <= to_d;
      load_q     <= load_d;
      fetch_q    <= fetch_d;
      done_q     <= done_d;
      err_q      <= err_d;
      idata_q    <= idata_d;
      digest_q   <= digest_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign digest    = digest_q;
  assign bus.load  = load_q;
  assign bus.fetch = fetch_q;
  assign bus.idata = idata_q;
endmodule

// File: tb/tb_sha256_host_driver.sv
// tb/tb_sha256_host_driver.sv - bench for sha256_host_driver with a behavioural SHA-256 slave and core
module tb_sha256_host_driver;
  localparam int GAP_CYC = 2;
  localparam int ACK_TO  = 15;
  localparam int CORE_TO = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] blk_in = '0;
  logic         ready, done, err;
  logic [255:0] digest;

  sha256_host_driver_if bus();

  sha256_host_driver #(.GAP_CYC(GAP_CYC), .ACK_TO(ACK_TO), .CORE_TO(CORE_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_in(blk_in), .ready(ready),
    .done(done), .digest(digest), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Single-block SHA-256 compression from the standard initial hash value.
  function automatic logic [255:0] sha_blk(input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = H0[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    return {H0[0] + v[0], H0[1] + v[1], H0[2] + v[2], H0[3] + v[3],
            H0[4] + v[4], H0[5] + v[5], H0[6] + v[6], H0[7] + v[7]};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
    return b;
  endfunction

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Slave knobs (written by the test) and observations (written by the slave).
  int s_ack_dly = 1, s_drop_idx = -1, s_busy_dly = 0, s_busy_len = 1, txn_id = 0;
  bit s_stuck = 1'b0;
  int cyc = 0, n_load = 0, n_fetch = 0, overlap = 0, gap_bad = 0, hold_bad = 0, drop_cyc = -1;
  logic [15:0]  words [$];
  logic [255:0] core_dig = '0;

  initial begin
    int pend, cnt, last_ack, ph, pcnt, seen_txn, fidx;
    logic [15:0]  req_data;
    logic [511:0] blk;
    pend = 0; cnt = 0; last_ack = -1; ph = 0; pcnt = 0; seen_txn = 0; fidx = 0; req_data = '0;
    bus.ack = 1'b0; bus.odata = '0; bus.busy_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.ack = 1'b0;
      if (!rst_n || seen_txn != txn_id) begin
        pend = 0; ph = 0; last_ack = -1; fidx = 0; bus.busy_valid = 1'b0;
        if (seen_txn != txn_id) begin
          n_load = 0; n_fetch = 0; overlap = 0; gap_bad = 0; hold_bad = 0; drop_cyc = -1;
          words.delete();
        end
        seen_txn = txn_id;
        if (!rst_n) continue;
      end
      case (ph)
        1: if (pcnt == 0) begin bus.busy_valid = 1'b1; ph = 2; pcnt = s_busy_len; end else pcnt--;
        2: if (!s_stuck) begin
             if (pcnt <= 1) begin bus.busy_valid = 1'b0; ph = 0; end else pcnt--;
           end
        default: ;
      endcase
      if (bus.load && bus.fetch) overlap++;
      if (bus.load || bus.fetch) begin
        if (last_ack >= 0 && cyc - last_ack != GAP_CYC + 1) gap_bad++;
        if (bus.load) begin
          n_load++;
          if (n_load - 1 == s_drop_idx) begin drop_cyc = cyc; pend = 0; end
          else begin pend = 1; cnt = s_ack_dly; req_data = bus.idata; end
        end else begin
          n_fetch++; pend = 2; cnt = s_ack_dly;
        end
      end else if (pend != 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.ack = 1'b1;
          last_ack = cyc;
          if (pend == 1) begin
            if (bus.idata !== req_data) hold_bad++;
            words.push_back(bus.idata);
            if (words.size() == 32) begin
              for (int i = 0; i < 32; i++) blk[511-16*i -: 16] = words[i];
              core_dig = sha_blk(blk);
              ph = 1; pcnt = s_busy_dly; last_ack = -1;
            end
          end else begin
            bus.odata = core_dig[255-16*fidx -: 16];
            fidx++;
          end
          pend = 0;
        end
      end
    end
  end

  typedef struct {
    logic [511:0] blk;
    logic [255:0] dig;
    int ack_dly, busy_dly, busy_len, drop_idx;
    bit stuck, exp_err;
    int exp_loads, exp_fetch;
  } vec_t;

  function automatic vec_t mk(input logic [511:0] b, input logic [255:0] d, input int a, input int bd,
                              input int bl, input int dr, input bit st, input bit e, input int nl, input int nf);
    vec_t v;
    v.blk = b; v.dig = d; v.ack_dly = a; v.busy_dly = bd; v.busy_len = bl; v.drop_idx = dr;
    v.stuck = st; v.exp_err = e; v.exp_loads = nl; v.exp_fetch = nf;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    bit got;
    int done_cyc, bad;
    logic [255:0] held;
    s_ack_dly = v.ack_dly; s_busy_dly = v.busy_dly; s_busy_len = v.busy_len;
    s_drop_idx = v.drop_idx; s_stuck = v.stuck;
    txn_id++;
    chk({tag, " ready_before"}, ready, 1'b1);
    start = 1'b1; blk_in = v.blk;
    @(posedge clk); #2;
    start = 1'b0; blk_in = rand_blk();
    chk({tag, " err_cleared"}, err, 1'b0);
    chk({tag, " busy_not_ready"}, ready, 1'b0);
    got = 1'b0; done_cyc = 0;
    for (int t = 0; t < 4000 && !got; t++) begin
      start = (t == 5);
      @(posedge clk); #2;
      if (done) begin got = 1'b1; done_cyc = cyc; end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, got, 1'b1);
    chk({tag, " err"}, err, v.exp_err);
    if (!v.exp_err) chk({tag, " digest"}, digest, v.dig);
    chk({tag, " load_count"}, n_load, v.exp_loads);
    chk({tag, " fetch_count"}, n_fetch, v.exp_fetch);
    chk({tag, " no_overlap"}, overlap, 0);
    chk({tag, " gap_cycles"}, gap_bad, 0);
    chk({tag, " idata_held"}, hold_bad, 0);
    bad = 0;
    for (int i = 0; i < words.size(); i++) if (words[i] !== v.blk[511-16*i -: 16]) bad++;
    chk({tag, " load_order"}, bad, 0);
    if (v.drop_idx >= 0) chk({tag, " ack_timeout_latency"}, done_cyc - drop_cyc, ACK_TO + 1);
    held = digest;
    @(posedge clk); #2;
    chk({tag, " done_one_cycle"}, {done, ready}, 2'b01);
    if (!v.exp_err) begin
      repeat (3) @(posedge clk);
      #2;
      chk({tag, " digest_holds"}, digest, held);
    end
  endtask

  vec_t vecs [10];

  initial begin
    logic [511:0] abc, rb;
    logic [255:0] abc_dig;
    bit reached;
    abc     = {32'h61626380, 448'h0, 32'h00000018};
    abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    vecs[0] = mk(abc, abc_dig, 1, 0, 1, -1, 0, 0, 32, 16);
    vecs[1] = mk(abc, abc_dig, 4, 10, 20, -1, 0, 0, 32, 16);
    for (int i = 2; i < 4; i++) begin
      rb = rand_blk();
      vecs[i] = mk(rb, sha_blk(rb), $urandom_range(1, ACK_TO), $urandom_range(0, 50),
                   $urandom_range(1, 50), -1, 0, 0, 32, 16);
    end
    rb = rand_blk();
    vecs[4] = mk(rb, sha_blk(rb), ACK_TO, CORE_TO - 1, CORE_TO, -1, 0, 0, 32, 16);
    vecs[5] = mk(rand_blk(), '0, 2, 0, 1, 4, 0, 1, 5, 0);
    vecs[6] = mk(abc, abc_dig, 2, 3, 5, -1, 0, 0, 32, 16);
    vecs[7] = mk(rand_blk(), '0, 1, 0, 1, -1, 1, 1, 32, 0);
    rb = rand_blk();
    vecs[8] = mk(rb, sha_blk(rb), 3, 7, 9, -1, 0, 0, 32, 16);
    vecs[9] = mk(rand_blk(), '0, ACK_TO + 1, 0, 1, -1, 0, 1, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("in_reset", {ready, bus.load, bus.fetch, done, err, bus.idata, digest}, {1'b1, 4'b0, 16'h0, 256'h0});
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      chk("idle_after_reset", {ready, bus.load, bus.fetch, done, err, digest}, {1'b1, 4'b0, 256'h0});
    end

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of the load phase, then a clean transaction.
    rb = rand_blk();
    s_ack_dly = 1; s_drop_idx = -1; s_busy_dly = 0; s_busy_len = 1; s_stuck = 1'b0;
    txn_id++;
    start = 1'b1; blk_in = rb;
    @(posedge clk); #2;
    start = 1'b0;
    reached = 1'b0;
    for (int t = 0; t < 2000 && !reached; t++) begin
      @(posedge clk); #2;
      if (n_load == 11) reached = 1'b1;
    end
    chk("reset_reached_word10", reached, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_load", {ready, bus.load, bus.fetch, done, err, bus.idata, digest}, {1'b1, 4'b0, 16'h0, 256'h0});
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    rb = rand_blk();
    run_txn(mk(rb, sha_blk(rb), 2, 4, 6, -1, 0, 0, 32, 16), "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
